// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the TMDS PLL lock sequencer:
// state encoding, the charge-pump / loop-filter setting table and helpers.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_WAIT = 3'd1,
    ST_STAB = 3'd2,
    ST_LOCK = 3'd3,
    ST_FAIL = 3'd4
  } state_e;

  localparam int unsigned NUM_SETTINGS = 8;

  typedef struct packed {
    logic [5:0] icpsel;
    logic [2:0] lpfres;
  } pll_setting_t;

  // Setting table: index 0 is the nominal point, later entries fan out
  // around it so a marginal PLL gets progressively different loop dynamics.
  function automatic pll_setting_t setting_lookup(input logic [2:0] idx);
    pll_setting_t s;
    case (idx)
      3'd0:    begin s.icpsel = 6'd16; s.lpfres = 3'd2; end
      3'd1:    begin s.icpsel = 6'd12; s.lpfres = 3'd2; end
      3'd2:    begin s.icpsel = 6'd20; s.lpfres = 3'd3; end
      3'd3:    begin s.icpsel = 6'd8;  s.lpfres = 3'd1; end
      3'd4:    begin s.icpsel = 6'd24; s.lpfres = 3'd3; end
      3'd5:    begin s.icpsel = 6'd6;  s.lpfres = 3'd1; end
      3'd6:    begin s.icpsel = 6'd28; s.lpfres = 3'd4; end
      3'd7:    begin s.icpsel = 6'd4;  s.lpfres = 3'd0; end
      default: begin s.icpsel = 6'd16; s.lpfres = 3'd2; end
    endcase
    return s;
  endfunction

  // Largest of three values, used to size the shared phase timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// Two-flop synchroniser bringing the raw PLL lock into the init_clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic meta_d;
  logic sync_q;
  logic sync_d;

  // Next-value logic for the two synchroniser stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL lock sequencer for the TMDS pixel/serial PLL.
// Pulses the PLL reset, waits for lock with a timeout, sweeps the
// ICPSEL/LPFRES table on timeout, qualifies lock before raising lock_out,
// and restarts on lock loss.  Build option PLL_LOSS_CNT_EN adds loss_cnt,
// a saturating count of lock-loss restarts.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned MAX_SWEEPS   = 2
) (
  input  logic       init_clk,
  input  logic       init_rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic       lock_out,
  output logic       fail,
  output logic [2:0] set_idx
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  localparam int unsigned TMAX = max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int unsigned TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
  localparam int unsigned SW   = ($clog2(MAX_SWEEPS + 1) < 1) ? 1 : $clog2(MAX_SWEEPS + 1);

  localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE - 1);
  localparam logic [SW-1:0] SWEEP_LIMIT  = SW'(MAX_SWEEPS);
  localparam logic [2:0]    LAST_IDX     = 3'(NUM_SETTINGS - 1);
  localparam pll_setting_t  SETTING_RST  = setting_lookup(3'd0);

  logic lock_s;

  state_e       state_q,   state_d;
  logic [TW-1:0] timer_q,  timer_d;
  logic [2:0]   set_idx_q, set_idx_d;
  logic [SW-1:0] sweep_q,  sweep_d;
  logic [SW-1:0] sweep_inc_s;
  logic         pll_rst_q, pll_rst_d;
  logic [5:0]   icpsel_q,  icpsel_d;
  logic [2:0]   lpfres_q,  lpfres_d;
  logic         lock_out_q, lock_out_d;
  logic         fail_q,    fail_d;
  pll_setting_t setting_s;

  sync_2ff u_lock_sync (
    .clk   (init_clk),
    .rst_n (init_rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // Next-state, table index, sweep count and phase timer.
  always_comb begin
    state_d     = state_q;
    set_idx_d   = set_idx_q;
    sweep_d     = sweep_q;
    timer_d     = timer_q;
    sweep_inc_s = sweep_q + SW'(1);

    if (relock_req) begin
      // A relock request beats every other transition this cycle.
      state_d   = ST_RST;
      set_idx_d = 3'd0;
      sweep_d   = '0;
    end else begin
      case (state_q)
        ST_RST: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RST;
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_d = ST_STAB;
          end else if (timer_q == TIMEOUT_LAST) begin
            if (set_idx_q != LAST_IDX) begin
              set_idx_d = set_idx_q + 3'd1;
              state_d   = ST_RST;
            end else begin
              // End of table: wrap and account one full sweep.
              set_idx_d = 3'd0;
              sweep_d   = sweep_inc_s;
              if (sweep_inc_s == SWEEP_LIMIT) begin
                state_d = ST_FAIL;
              end else begin
                state_d = ST_RST;
              end
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_STAB: begin
          if (!lock_s) begin
            state_d = ST_WAIT;
          end else if (timer_q == STABLE_LAST) begin
            state_d = ST_LOCK;
          end else begin
            state_d = ST_STAB;
          end
        end
        ST_LOCK: begin
          if (!lock_s) begin
            // Lock lost: retry with the setting that worked last time.
            state_d = ST_RST;
            sweep_d = '0;
          end else begin
            state_d = ST_LOCK;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d   = ST_RST;
          set_idx_d = 3'd0;
          sweep_d   = '0;
        end
      endcase
    end

    // Timer restarts on every state entry (including a relock while in RST)
    // and only runs in the states that have a terminal count.
    if (relock_req || (state_d != state_q)) begin
      timer_d = '0;
    end else if ((state_q == ST_RST) || (state_q == ST_WAIT) || (state_q == ST_STAB)) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end
  end

  // Registered outputs derived from the next state; PLL settings load only
  // when entering or sitting in RST so they are settled before reset release.
  always_comb begin
    pll_rst_d  = (state_d == ST_RST) || (state_d == ST_FAIL);
    lock_out_d = (state_d == ST_LOCK);
    fail_d     = (state_d == ST_FAIL);
    setting_s  = setting_lookup(set_idx_d);
    if (state_d == ST_RST) begin
      icpsel_d = setting_s.icpsel;
      lpfres_d = setting_s.lpfres;
    end else begin
      icpsel_d = icpsel_q;
      lpfres_d = lpfres_q;
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge init_clk) begin
    if (!init_rst_n) begin
      state_q    <= ST_RST;
      timer_q    <= '0;
      set_idx_q  <= 3'd0;
      sweep_q    <= '0;
      pll_rst_q  <= 1'b1;
      icpsel_q   <= SETTING_RST.icpsel;
      lpfres_q   <= SETTING_RST.lpfres;
      lock_out_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      set_idx_q  <= set_idx_d;
      sweep_q    <= sweep_d;
      pll_rst_q  <= pll_rst_d;
      icpsel_q   <= icpsel_d;
      lpfres_q   <= lpfres_d;
      lock_out_q <= lock_out_d;
      fail_q     <= fail_d;
    end
  end

  assign pll_rst  = pll_rst_q;
  assign icpsel   = icpsel_q;
  assign lpfres   = lpfres_q;
  assign lock_out = lock_out_q;
  assign fail     = fail_q;
  assign set_idx  = set_idx_q;

`ifdef PLL_LOSS_CNT_EN
  logic       loss_event_s;
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Saturating count of LOCK->RST restarts caused by lock loss.
  always_comb begin
    loss_event_s = (state_q == ST_LOCK) && !lock_s && !relock_req;
    if (relock_req) begin
      loss_cnt_d = 8'd0;
    end else if (loss_event_s && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end else begin
      loss_cnt_d = loss_cnt_q;
    end
  end

  // Loss counter register.
  always_ff @(posedge init_clk) begin
    if (!init_rst_n) begin
      loss_cnt_q <= 8'd0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign loss_cnt = loss_cnt_q;
`endif

endmodule
